// File: rtl/sys_counter_prog.sv
// sys_counter_prog: programmable up/down counter with a prescaler, load, clear,
// wrap or saturate at the range ends, a registered terminal-count pulse and a
// combinational compare match. It serves as a general timebase and as a
// countdown engine.
module sys_counter_prog #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter int unsigned      PRESCALE = 1,
  parameter int               SATURATE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             En,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  input  logic             Dir,
  input  logic [WIDTH-1:0] CmpVal,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc,
  output logic             match
);

  // The prescaler needs at least one bit, even when PRESCALE is 1.
  localparam int unsigned     PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] terminal;
  logic [WIDTH-1:0] load_clamped;

  // The prescaler reaching its last phase yields a step, unless clear or load wins.
  assign tick = En & (presc_q == PRESC_LAST) & ~Clr & ~Load;

  // The terminal value follows the current direction, so a Dir change is seen on the next tick.
  assign terminal = Dir ? MAX_VAL : '0;

  // Loads above the ceiling are clamped so the count never leaves 0..MAX_VAL.
  assign load_clamped = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;

  // Next count for a step: move one toward the range end, then wrap or hold there.
  always_comb begin
    step_val = count_q;
    if (Dir) begin
      if (count_q == MAX_VAL) begin
        step_val = (SATURATE != 0) ? MAX_VAL : '0;
      end else begin
        step_val = count_q + WIDTH'(1);
      end
    end else begin
      if (count_q == '0) begin
        step_val = (SATURATE != 0) ? '0 : MAX_VAL;
      end else begin
        step_val = count_q - WIDTH'(1);
      end
    end
  end

  // Next-state selection with priority: clear, then load, then step or prescale, otherwise hold.
  always_comb begin
    count_d = count_q;
    presc_d = presc_q;
    tc_d    = 1'b0;
    if (Clr) begin
      count_d = '0;
      presc_d = '0;
    end else if (Load) begin
      count_d = load_clamped;
      presc_d = '0;
    end else if (En) begin
      if (tick) begin
        presc_d = '0;
        count_d = step_val;
        // Pulse only on arrival at the terminal value, never while resting on it.
        tc_d    = (step_val == terminal) && (count_q != terminal);
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // State registers; asynchronous reset also drops any pending terminal-count pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count_q <= '0;
      presc_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign match = (count_q == CmpVal);

endmodule

// File: tb/tb_sys_counter_prog.sv
// Testbench for sys_counter_prog: three instances cover a prescaled 8-bit
// counter, a wrapping 0..59 counter and a saturating 0..59 counter. Expected
// count/tc pairs are queued when stimulus is driven and popped after each edge.
module tb_sys_counter_prog;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
  } exp_t;

  logic       Clk;
  logic       Rst;

  logic       a_en, a_clr, a_load, a_dir;
  logic [7:0] a_lv, a_cmp, a_count;
  logic       a_tick, a_tc, a_match;

  logic       b_en, b_clr, b_load, b_dir;
  logic [7:0] b_lv, b_cmp, b_count;
  logic       b_tick, b_tc, b_match;

  logic       c_en, c_clr, c_load, c_dir;
  logic [7:0] c_lv, c_cmp, c_count;
  logic       c_tick, c_tc, c_match;

  exp_t sb_q[$];
  exp_t got;
  int   n_checks = 0;
  int   n_pass   = 0;

  sys_counter_prog #(.WIDTH(8), .MAX_VAL(8'd255), .PRESCALE(4), .SATURATE(0)) dut_a (
    .Clk(Clk), .Rst(Rst), .En(a_en), .Clr(a_clr), .Load(a_load), .LoadVal(a_lv),
    .Dir(a_dir), .CmpVal(a_cmp), .count(a_count), .tick(a_tick), .tc(a_tc), .match(a_match)
  );

  sys_counter_prog #(.WIDTH(8), .MAX_VAL(8'd59), .PRESCALE(1), .SATURATE(0)) dut_b (
    .Clk(Clk), .Rst(Rst), .En(b_en), .Clr(b_clr), .Load(b_load), .LoadVal(b_lv),
    .Dir(b_dir), .CmpVal(b_cmp), .count(b_count), .tick(b_tick), .tc(b_tc), .match(b_match)
  );

  sys_counter_prog #(.WIDTH(8), .MAX_VAL(8'd59), .PRESCALE(1), .SATURATE(1)) dut_c (
    .Clk(Clk), .Rst(Rst), .En(c_en), .Clr(c_clr), .Load(c_load), .LoadVal(c_lv),
    .Dir(c_dir), .CmpVal(c_cmp), .count(c_count), .tick(c_tick), .tc(c_tc), .match(c_match)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reset held for 3 edges with En=1, then 10 idle cycles with En=0.
  task automatic test_reset();
    Rst = 1'b0;
    a_en = 1'b1;
    repeat (3) begin
      @(posedge Clk); #1;
      n_checks++;
      if (a_count !== 8'd0 || a_tc !== 1'b0)
        $display("FAIL reset_a: count=%0d tc=%0d, required count=0 tc=0", a_count, a_tc);
      else n_pass++;
      n_checks++;
      if (b_count !== 8'd0 || c_count !== 8'd0)
        $display("FAIL reset_bc: b=%0d c=%0d, required 0 0", b_count, c_count);
      else n_pass++;
    end
    @(negedge Clk);
    Rst  = 1'b1;
    a_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (a_tick !== 1'b0) $display("FAIL idle_tick: tick=%0d, required 0", a_tick);
      else n_pass++;
      sb_q.push_back('{count: 8'd0, tc: 1'b0});
      @(posedge Clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (a_count !== got.count || a_tc !== got.tc)
        $display("FAIL idle_hold: count=%0d tc=%0d, required count=%0d tc=%0d", a_count, a_tc, got.count, got.tc);
      else n_pass++;
      @(negedge Clk);
    end
  endtask

  // Prescaled up count on instance A; phase/count tracked by a small model.
  task automatic run_a(input int cycles, input logic en, inout int ph, inout int cnt, input string tag);
    logic exp_tick;
    for (int i = 0; i < cycles; i++) begin
      a_en = en;
      #1;
      exp_tick = en && (ph == 3);
      n_checks++;
      if (a_tick !== exp_tick)
        $display("FAIL %s_tick: tick=%0d, required %0d (cycle %0d)", tag, a_tick, exp_tick, i);
      else n_pass++;
      if (en) begin
        if (ph == 3) begin ph = 0; cnt = cnt + 1; end
        else ph = ph + 1;
      end
      sb_q.push_back('{count: 8'(cnt), tc: 1'b0});
      @(posedge Clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (a_count !== got.count || a_tc !== got.tc)
        $display("FAIL %s_count: count=%0d tc=%0d, required count=%0d tc=%0d", tag, a_count, a_tc, got.count, got.tc);
      else n_pass++;
      n_checks++;
      if (a_match !== (8'(cnt) == a_cmp))
        $display("FAIL %s_match: match=%0d, required %0d (count %0d cmp %0d)", tag, a_match, (8'(cnt) == a_cmp), a_count, a_cmp);
      else n_pass++;
      @(negedge Clk);
    end
  endtask

  task automatic test_prescale();
    int ph = 0;
    int cnt = 0;
    a_dir = 1'b1;
    a_cmp = 8'd200;
    run_a(40, 1'b1, ph, cnt, "presc");
    n_checks++;
    if (a_count !== 8'd10) $display("FAIL presc_total: count=%0d, required 10", a_count);
    else n_pass++;
    run_a(2, 1'b1, ph, cnt, "presc_pre");
    run_a(5, 1'b0, ph, cnt, "presc_frozen");
    run_a(3, 1'b1, ph, cnt, "presc_resume");
    $display("prescale: count=%0d after resume", a_count);
  endtask

  // Load 57 into the wrapping 0..59 counter, then 4 steps up.
  task automatic test_wrap();
    exp_t seq[4];
    seq[0] = '{count: 8'd58, tc: 1'b0};
    seq[1] = '{count: 8'd59, tc: 1'b1};
    seq[2] = '{count: 8'd0,  tc: 1'b0};
    seq[3] = '{count: 8'd1,  tc: 1'b0};
    b_dir = 1'b1; b_en = 1'b1; b_load = 1'b1; b_lv = 8'd57; b_cmp = 8'd59;
    #1;
    n_checks++;
    if (b_tick !== 1'b0) $display("FAIL wrap_load_tick: tick=%0d, required 0", b_tick);
    else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (b_count !== 8'd57 || b_tc !== 1'b0)
      $display("FAIL wrap_load: count=%0d tc=%0d, required 57 0", b_count, b_tc);
    else n_pass++;
    @(negedge Clk);
    b_load = 1'b0;
    for (int i = 0; i < 4; i++) sb_q.push_back(seq[i]);
    for (int i = 0; i < 4; i++) begin
      @(posedge Clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (b_count !== got.count || b_tc !== got.tc)
        $display("FAIL wrap_step%0d: count=%0d tc=%0d, required count=%0d tc=%0d", i, b_count, b_tc, got.count, got.tc);
      else n_pass++;
      n_checks++;
      if (b_match !== (got.count == 8'd59))
        $display("FAIL wrap_match%0d: match=%0d, required %0d", i, b_match, (got.count == 8'd59));
      else n_pass++;
      $display("wrap: count=%0d tc=%0d", b_count, b_tc);
    end
    @(negedge Clk);
    b_en = 1'b0;
  endtask

  // Load 3 into the saturating counter, then 8 steps down.
  task automatic test_saturate();
    c_dir = 1'b0; c_en = 1'b1; c_load = 1'b1; c_lv = 8'd3; c_cmp = 8'd0;
    #1;
    n_checks++;
    if (c_tick !== 1'b0) $display("FAIL sat_load_tick: tick=%0d, required 0", c_tick);
    else n_pass++;
    @(posedge Clk); #1;
    n_checks++;
    if (c_count !== 8'd3 || c_tc !== 1'b0)
      $display("FAIL sat_load: count=%0d tc=%0d, required 3 0", c_count, c_tc);
    else n_pass++;
    @(negedge Clk);
    c_load = 1'b0;
    sb_q.push_back('{count: 8'd2, tc: 1'b0});
    sb_q.push_back('{count: 8'd1, tc: 1'b0});
    sb_q.push_back('{count: 8'd0, tc: 1'b1});
    for (int i = 0; i < 5; i++) sb_q.push_back('{count: 8'd0, tc: 1'b0});
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (c_count !== got.count || c_tc !== got.tc)
        $display("FAIL sat_step%0d: count=%0d tc=%0d, required count=%0d tc=%0d", i, c_count, c_tc, got.count, got.tc);
      else n_pass++;
      $display("saturate: count=%0d tc=%0d", c_count, c_tc);
    end
    n_checks++;
    if (c_match !== 1'b1) $display("FAIL sat_match: match=%0d, required 1", c_match);
    else n_pass++;
    @(negedge Clk);
    c_en = 1'b0;
  endtask

  // Clear/load/step priority and load clamping on instance B.
  task automatic test_priority();
    b_en = 1'b1; b_dir = 1'b1; b_clr = 1'b1; b_load = 1'b1; b_lv = 8'd30;
    #1;
    n_checks++;
    if (b_tick !== 1'b0) $display("FAIL prio_tick: tick=%0d, required 0", b_tick);
    else n_pass++;
    sb_q.push_back('{count: 8'd0, tc: 1'b0});
    @(posedge Clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (b_count !== got.count || b_tc !== got.tc)
      $display("FAIL prio_clr: count=%0d tc=%0d, required %0d %0d", b_count, b_tc, got.count, got.tc);
    else n_pass++;
    @(negedge Clk);
    b_clr = 1'b0; b_lv = 8'd200;
    sb_q.push_back('{count: 8'd59, tc: 1'b0});
    @(posedge Clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (b_count !== got.count || b_tc !== got.tc)
      $display("FAIL prio_clamp: count=%0d tc=%0d, required %0d %0d", b_count, b_tc, got.count, got.tc);
    else n_pass++;
    @(negedge Clk);
    b_dir = 1'b0; b_lv = 8'd0;
    sb_q.push_back('{count: 8'd0, tc: 1'b0});
    @(posedge Clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (b_count !== got.count || b_tc !== got.tc)
      $display("FAIL prio_load_zero: count=%0d tc=%0d, required %0d %0d", b_count, b_tc, got.count, got.tc);
    else n_pass++;
    @(negedge Clk);
    b_load = 1'b0; b_en = 1'b0;
  endtask

  // Compare match while counting up from 0 on the prescaled instance.
  task automatic test_compare();
    int ph = 0;
    int cnt = 0;
    a_clr = 1'b1; a_en = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if (a_count !== 8'd0) $display("FAIL cmp_clear: count=%0d, required 0", a_count);
    else n_pass++;
    @(negedge Clk);
    a_clr = 1'b0; a_dir = 1'b1; a_cmp = 8'd5;
    run_a(30, 1'b1, ph, cnt, "cmp");
  endtask

  // Asynchronous reset applied between edges must clear outputs immediately.
  task automatic test_async_reset();
    b_en = 1'b1; b_dir = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #3;
    Rst = 1'b0;
    #1;
    n_checks++;
    if (a_count !== 8'd0 || a_tc !== 1'b0)
      $display("FAIL async_a: count=%0d tc=%0d, required 0 0", a_count, a_tc);
    else n_pass++;
    n_checks++;
    if (b_count !== 8'd0 || c_count !== 8'd0)
      $display("FAIL async_bc: b=%0d c=%0d, required 0 0", b_count, c_count);
    else n_pass++;
    @(negedge Clk);
    Rst = 1'b1;
    a_en = 1'b0; b_en = 1'b0;
  endtask

  initial begin
    Rst = 1'b0;
    a_en = 1'b0; a_clr = 1'b0; a_load = 1'b0; a_dir = 1'b1; a_lv = '0; a_cmp = '0;
    b_en = 1'b0; b_clr = 1'b0; b_load = 1'b0; b_dir = 1'b1; b_lv = '0; b_cmp = '0;
    c_en = 1'b0; c_clr = 1'b0; c_load = 1'b0; c_dir = 1'b1; c_lv = '0; c_cmp = '0;
    test_reset();
    test_prescale();
    test_wrap();
    test_saturate();
    test_priority();
    test_compare();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sys_counter_prog.md
Name: sys_counter_prog

Overview:
- Parametrised successor to the system counter: programmable up/down counter with prescaler, load, wrap or saturate mode, terminal-count pulse and compare match.
- Used as the general timebase and cook-time countdown engine in the microwave controller.
- Replaces fixed-width, enable-only counting with configurable width, ceiling and direction.

Parameters:
- WIDTH, 32, counter width in bits.
- MAX_VAL, 2**WIDTH-1, count ceiling; counter range is 0..MAX_VAL. Must satisfy 1 <= MAX_VAL <= 2**WIDTH-1.
- PRESCALE, 1, number of enabled clock cycles per count step; must be >= 1; prescaler width is clog2(PRESCALE), min 1.
- SATURATE, 0, 0 = wrap at range ends; 1 = hold at range ends.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous reset, active-low.
- En  in  1  count enable; when low, prescaler and count both hold.
- Clr  in  1  synchronous clear.
- Load  in  1  synchronous load strobe.
- LoadVal  in  WIDTH  value written on Load.
- Dir  in  1  1 = up, 0 = down.
- CmpVal  in  WIDTH  compare value.
- count  out  WIDTH  current count.
- tick  out  1  prescaler step strobe (combinational).
- tc  out  1  terminal-count pulse (registered).
- match  out  1  high when count == CmpVal (combinational).

Behaviour:
- Reset (Rst low, asynchronous): count=0, prescaler=0, tc=0. Outputs stay at reset values until the first rising Clk edge after Rst rises.
- Priority per edge: Clr > Load > step > hold.
- Clr: count=0, prescaler=0, tc=0.
- Load: count=min(LoadVal, MAX_VAL), prescaler=0, tc=0. Load never generates tc, even when the loaded value is terminal.
- Prescaler:
  - Counts 0..PRESCALE-1 while En=1 (and no Clr/Load).
  - tick = En & (prescaler == PRESCALE-1) & ~Clr & ~Load.
  - On tick the prescaler returns to 0. With PRESCALE=1, tick = En & ~Clr & ~Load.
- Step (on tick):
  - Up: count+1. If count == MAX_VAL: wrap to 0 (SATURATE=0) or hold at MAX_VAL (SATURATE=1).
  - Down: count-1. If count == 0: wrap to MAX_VAL (SATURATE=0) or hold at 0 (SATURATE=1).
  - Arithmetic is WIDTH bits. No intermediate value exceeds MAX_VAL.
- Terminal value: MAX_VAL when Dir=1; 0 when Dir=0.
- tc:
  - Registered; high for exactly one cycle.
  - Asserted on the edge where a step moves count from a non-terminal value to the terminal value, so tc and the new count appear together.
  - When saturated at terminal, further ticks hold count and keep tc=0.
  - In wrap mode, stepping past the terminal leaves terminal; tc=0 that cycle.
- Dir change: takes effect on the next tick. The prescaler is not disturbed.
- En low mid-prescale: the prescaler holds its value and resumes when En returns; no tick is lost or duplicated.
- match: purely combinational; independent of En and tick.
- Reset mid-count: immediate asynchronous return to reset values. A pending tc is dropped.

Test Plan:
- Reset/hold: Rst low for 3 cycles with En=1 -> count=0, tc=0. Rst high, En=0 for 10 cycles -> count stays 0, tick never asserted.
- Prescaled up count: PRESCALE=4, WIDTH=8, Dir=1, En=1 for 40 cycles -> tick every 4th cycle, count=10. En dropped for 5 cycles mid-prescale -> count frozen; tick resumes after the remaining prescale cycles.
- Wrap and tc: SATURATE=0, MAX_VAL=59, Load 57, Dir=1, PRESCALE=1 -> count 58, 59 (tc=1 only on the 59 cycle), then 0, 1 with tc=0.
- Saturating countdown: SATURATE=1, Load 3, Dir=0 -> count 2, 1, 0 (tc=1 on the 0 cycle), then holds at 0 for 5 more ticks with tc=0.
- Priority and clamp: Clr, Load and tick together -> count=0. Load alone with LoadVal=200 and MAX_VAL=59 -> count=59, tc=0. Load with LoadVal=0 while Dir=0 -> count=0, tc=0.
- Compare/async reset: CmpVal=5 while counting up from 0 -> match high exactly while count=5. Rst pulsed low between edges -> count=0 before the next Clk edge.
